// File: rtl/cpu_defs.sv
// Definitions shared between the program sequencer and simple_cpu:
// datapath widths, the HALT sentinel word and the sequencer state encoding.
package cpu_defs;

    localparam int CPU_INSTR_WIDTH = 20;
    localparam int CPU_DATA_WIDTH  = 8;
    localparam int CPU_ADDR_BITS   = 2;

    localparam logic [CPU_INSTR_WIDTH-1:0] HALT_WORD = 20'hFFFFF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/prog_mem.sv
// Program store for the sequencer: synchronous write, asynchronous read,
// so the fetch logic can look ahead one word within the same cycle.
module prog_mem
    import cpu_defs::*;
#(
    parameter int WIDTH     = CPU_INSTR_WIDTH,
    parameter int ADDR_BITS = 5
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [WIDTH-1:0]     wr_data,
    input  logic [ADDR_BITS-1:0] rd_addr,
    output logic [WIDTH-1:0]     rd_data
);

    logic [WIDTH-1:0] mem [2**ADDR_BITS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/instr_fetch.sv
// Program sequencer feeding simple_cpu: steps a PC through prog_mem and
// presents each word for HOLD_CYCLES edges until HALT or end of memory.
//
//   state  | meaning
//   IDLE   | after reset, instruction=0, waiting for start
//   RUN    | presenting mem[pc], hold counter running
//   HALTED | run finished, instruction=0, pc keeps last address, done=1
module instr_fetch
    import cpu_defs::*;
#(
    parameter int INSTR_WIDTH = CPU_INSTR_WIDTH,
    parameter int PC_BITS     = 5,
    parameter int HOLD_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load_en,
    input  logic [PC_BITS-1:0]     load_addr,
    input  logic [INSTR_WIDTH-1:0] load_data,
    input  logic                   start,
    output logic [INSTR_WIDTH-1:0] instruction,
    output logic [PC_BITS-1:0]     pc,
    output logic                   busy,
    output logic                   done
);

    localparam logic [INSTR_WIDTH-1:0] HALT      = '1;
    localparam logic [PC_BITS-1:0]     PC_LAST   = '1;
    localparam logic [3:0]             HOLD_LAST = 4'(HOLD_CYCLES - 1);

    fetch_state_t             state, state_nxt;
    logic [INSTR_WIDTH-1:0]   instr_nxt;
    logic [INSTR_WIDTH-1:0]   rd_data;
    logic [INSTR_WIDTH-1:0]   fetch_data;
    logic [PC_BITS-1:0]       pc_nxt;
    logic [PC_BITS-1:0]       rd_addr;
    logic [3:0]               hold_cnt, hold_nxt;
    logic                     wr_en;

    // Outside RUN the only word ever fetched is address 0; in RUN look ahead to pc+1.
    assign wr_en   = load_en && (state != RUN) && !rst;
    assign rd_addr = (state == RUN) ? pc + PC_BITS'(1) : '0;

    // Write-first: a load to the fetched address in the start cycle is seen immediately.
    assign fetch_data = (wr_en && (load_addr == rd_addr)) ? load_data : rd_data;

    prog_mem #(
        .WIDTH     (INSTR_WIDTH),
        .ADDR_BITS (PC_BITS)
    ) u_prog_mem (
        .clk     (clk),
        .we      (wr_en),
        .wr_addr (load_addr),
        .wr_data (load_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_comb begin
        state_nxt = state;
        instr_nxt = instruction;
        pc_nxt    = pc;
        hold_nxt  = hold_cnt;
        case (state)
            IDLE, HALTED: begin
                if (start) begin
                    pc_nxt   = '0;
                    hold_nxt = '0;
                    if (fetch_data == HALT) begin
                        state_nxt = HALTED;
                        instr_nxt = '0;
                    end else begin
                        state_nxt = RUN;
                        instr_nxt = fetch_data;
                    end
                end
            end
            RUN: begin
                if (hold_cnt == HOLD_LAST) begin
                    hold_nxt = '0;
                    if ((pc == PC_LAST) || (fetch_data == HALT)) begin
                        state_nxt = HALTED;
                        instr_nxt = '0;
                    end else begin
                        pc_nxt    = pc + PC_BITS'(1);
                        instr_nxt = fetch_data;
                    end
                end else begin
                    hold_nxt = hold_cnt + 4'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                instr_nxt = '0;
                pc_nxt    = '0;
                hold_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            instruction <= '0;
            pc          <= '0;
            hold_cnt    <= '0;
        end else begin
            state       <= state_nxt;
            instruction <= instr_nxt;
            pc          <= pc_nxt;
            hold_cnt    <= hold_nxt;
        end
    end

    assign busy = (state == RUN);
    assign done = (state == HALTED);

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: one instance with HOLD_CYCLES=4 and one
// with HOLD_CYCLES=1 share all inputs; expected values are hand-computed.
module tb_instr_fetch;

    localparam logic [19:0] P0   = 20'b01000111000000000000;
    localparam logic [19:0] P1   = 20'b01010011000000000000;
    localparam logic [19:0] P2   = 20'b01110010000000000001;
    localparam logic [19:0] HALT = 20'hFFFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_en;
    logic [4:0]  load_addr;
    logic [19:0] load_data;
    logic        start;

    logic [19:0] instruction, instruction_h1;
    logic [4:0]  pc, pc_h1;
    logic        busy, busy_h1, done, done_h1;

    int n_checks = 0;
    int n_errors = 0;

    logic [19:0] prog [3];

    always #5 clk = ~clk;

    instr_fetch #(.INSTR_WIDTH(20), .PC_BITS(5), .HOLD_CYCLES(4)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .load_en     (load_en),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .start       (start),
        .instruction (instruction),
        .pc          (pc),
        .busy        (busy),
        .done        (done)
    );

    instr_fetch #(.INSTR_WIDTH(20), .PC_BITS(5), .HOLD_CYCLES(1)) u_dut_h1 (
        .clk         (clk),
        .rst         (rst),
        .load_en     (load_en),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .start       (start),
        .instruction (instruction_h1),
        .pc          (pc_h1),
        .busy        (busy_h1),
        .done        (done_h1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [4:0] addr, input logic [19:0] data);
        load_en   = 1'b1;
        load_addr = addr;
        load_data = data;
        tick();
        load_en   = 1'b0;
    endtask

    task automatic wait_done(input int max_cycles);
        int n = 0;
        while (!done && n < max_cycles) begin
            tick();
            n++;
        end
        chk("wait_done_timeout", {31'd0, done}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        prog[0] = P0;
        prog[1] = P1;
        prog[2] = P2;
        rst = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0; start = 1'b0;
        #1;
        tick(); tick();
        chk("rst_instr", {12'd0, instruction}, 32'd0);
        chk("rst_busy",  {31'd0, busy}, 32'd0);
        rst = 1'b0;

        load(5'd0, P0); load(5'd1, P1); load(5'd2, P2); load(5'd3, HALT);

        // reset with memory preloaded
        rst = 1'b1; tick(); rst = 1'b0;
        chk("rst2_instr", {12'd0, instruction}, 32'd0);
        chk("rst2_pc",    {27'd0, pc}, 32'd0);
        chk("rst2_busy",  {31'd0, busy}, 32'd0);
        chk("rst2_done",  {31'd0, done}, 32'd0);

        // basic run: each word held 4 edges, done at E12
        start = 1'b1; tick(); start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            for (int h = 0; h < 4; h++) begin
                chk("run_instr", {12'd0, instruction}, {12'd0, prog[k]});
                chk("run_pc",    {27'd0, pc}, k);
                chk("run_busy",  {30'd0, busy, done}, 32'd2);
                tick();
            end
        end
        chk("run_end_instr", {12'd0, instruction}, 32'd0);
        chk("run_end_pc",    {27'd0, pc}, 32'd2);
        chk("run_end_flags", {30'd0, busy, done}, 32'd1);

        // reset sampled at E6 aborts the run; restart replays from address 0
        start = 1'b1; tick(); start = 1'b0;
        repeat (5) tick();
        chk("mid_pc_e5", {27'd0, pc}, 32'd1);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("abort_instr", {12'd0, instruction}, 32'd0);
        chk("abort_flags", {30'd0, busy, done}, 32'd0);
        chk("abort_pc",    {27'd0, pc}, 32'd0);
        start = 1'b1; tick(); start = 1'b0;
        chk("replay_e0", {12'd0, instruction}, {12'd0, P0});
        repeat (4) tick();
        chk("replay_e4", {12'd0, instruction}, {12'd0, P1});
        chk("replay_pc", {27'd0, pc}, 32'd1);
        repeat (8) tick();
        chk("replay_done", {30'd0, busy, done}, 32'd1);

        // load and start during RUN are ignored
        start = 1'b1; tick(); start = 1'b0;
        load_en = 1'b1; load_addr = 5'd1; load_data = 20'hABCDE; start = 1'b1;
        tick();
        load_en = 1'b0;
        repeat (3) tick();
        chk("runload_e4", {12'd0, instruction}, {12'd0, P1});
        chk("runstart_pc4", {27'd0, pc}, 32'd1);
        start = 1'b0;
        repeat (4) tick();
        chk("runstart_pc8", {27'd0, pc}, 32'd2);
        chk("runload_e8", {12'd0, instruction}, {12'd0, P2});
        repeat (4) tick();
        chk("runload_done", {30'd0, busy, done}, 32'd1);

        // HALT at address 0: straight to HALTED
        load(5'd0, HALT);
        start = 1'b1; tick(); start = 1'b0;
        chk("halt0_flags", {30'd0, busy, done}, 32'd1);
        chk("halt0_instr", {12'd0, instruction}, 32'd0);
        tick();
        chk("halt0_busy", {31'd0, busy}, 32'd0);

        // simultaneous load to address 0 and start: write-first
        load_en = 1'b1; load_addr = 5'd0; load_data = P0; start = 1'b1;
        tick();
        load_en = 1'b0; start = 1'b0;
        chk("wfirst_instr", {12'd0, instruction}, {12'd0, P0});
        chk("wfirst_busy",  {31'd0, busy}, 32'd1);
        wait_done(20);
        chk("wfirst_pc", {27'd0, pc}, 32'd2);

        // no HALT anywhere: pc runs 0..31, never wraps
        for (int i = 0; i < 32; i++) begin
            load(5'(i), 20'h00100 + 20'(i));
        end
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 32; i++) begin
            chk("h1_pc",    {27'd0, pc_h1}, i);
            chk("h1_instr", {12'd0, instruction_h1}, 32'h100 + i);
            chk("h1_busy",  {30'd0, busy_h1, done_h1}, 32'd2);
            tick();
        end
        chk("h1_end_flags", {30'd0, busy_h1, done_h1}, 32'd1);
        chk("h1_end_pc",    {27'd0, pc_h1}, 32'd31);
        chk("h1_end_instr", {12'd0, instruction_h1}, 32'd0);
        repeat (95) tick();
        chk("h4_last_pc",    {27'd0, pc}, 32'd31);
        chk("h4_last_instr", {12'd0, instruction}, 32'h11F);
        chk("h4_last_busy",  {31'd0, busy}, 32'd1);
        tick();
        chk("h4_end_flags", {30'd0, busy, done}, 32'd1);
        chk("h4_end_pc",    {27'd0, pc}, 32'd31);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Program sequencer that sits directly upstream of `simple_cpu`. It holds a small writable program memory, steps a program counter through it, and drives each 20-bit instruction onto the CPU's `instruction` input for a fixed number of clock edges. This removes hand-timed instruction sequencing from benches and top levels. Runs start on `start` and stop on a HALT sentinel or at the end of memory.

## Interface
- `INSTR_WIDTH`, 20: instruction width; matches `simple_cpu`.
- `PC_BITS`, 5: program memory depth is 2^PC_BITS (32 entries).
- `HOLD_CYCLES`, 4: rising edges each instruction is presented; legal range 1..15.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `load_en` in 1: program memory write strobe.
- `load_addr` in PC_BITS: write address.
- `load_data` in INSTR_WIDTH: write data.
- `start` in 1: start a run from address 0. Single-cycle pulse or level.
- `instruction` out INSTR_WIDTH: instruction to `simple_cpu`, registered.
- `pc` out PC_BITS: address of the instruction currently presented, registered.
- `busy` out 1: high in RUN.
- `done` out 1: high in HALTED.

## Operation
- States are IDLE, RUN and HALTED.
- Reset:
  - state goes to IDLE; `instruction`=0, `pc`=0, `busy`=0, `done`=0, hold counter=0.
  - Program memory is not cleared.
- Loading:
  - `load_en`=1 in IDLE or HALTED writes `load_data` to `mem[load_addr]` at the edge.
  - `load_en` in RUN is ignored and memory is unchanged.
- IDLE:
  - `instruction` stays 0, which the CPU treats as a no-op.
  - `start`=1 moves to RUN.
- RUN:
  - presents `mem[pc]` for exactly HOLD_CYCLES edges.
  - On the last hold edge the next address is evaluated:
    - if `pc` = 2^PC_BITS−1, go to HALTED;
    - else if `mem[pc+1]` = HALT (all ones, 20'hFFFFF), go to HALTED;
    - otherwise `pc` increments and the next instruction is presented.
  - The HALT word is never driven onto `instruction`.
  - `start` is ignored in RUN.
- HALTED:
  - `instruction`=0, `pc` holds the last executed address, `done`=1.
  - `start` restarts at address 0 as in IDLE.
- A HALT word at address 0 starts nothing: `start` goes directly to HALTED with `instruction` staying 0.
- Simultaneous `start` and `load_en` in IDLE/HALTED:
  - the write takes effect;
  - the first fetch sees the written data if `load_addr`=0 (write-first).
- `rst` has priority over everything. Asserting it mid-RUN aborts at the next edge and memory contents are kept.

## Timing
- `start` is sampled at edge E0. At E0: `instruction`=mem[0], `pc`=0, `busy`=1.
- Instruction k is presented for edges E(k·H)..E(k·H+H−1), where H=HOLD_CYCLES. At edge E(k·H+H) it is replaced by instruction k+1, or by 0 with `done`=1.
- With N instructions before HALT, `busy` is high for exactly N·H cycles.
- Outputs update only on rising `clk`. There are no combinational paths from inputs to outputs.
- Hold counter width is 4 bits. It resets to 0 on each new instruction and on leaving RUN.

## Structure
- Shared package/include `cpu_defs`:
  - INSTR_WIDTH, DATA_WIDTH, ADDR_BITS;
  - HALT word;
  - state encodings (IDLE=2'd0, RUN=2'd1, HALTED=2'd2).
- One sub-module, `prog_mem`: 2^PC_BITS × INSTR_WIDTH, synchronous write port, asynchronous read port.
- FSM, PC and hold counter live in `instr_fetch`.

## Test plan
- Reset with memory preloaded: `instruction`=0, `pc`=0, `busy`=0, `done`=0. Memory contents survive reset (read back via a run).
- Load mem[0..2] = 20'b01000111000000000000, 20'b01010011000000000000, 20'b01110010000000000001, then mem[3]=HALT, HOLD_CYCLES=4.
  - Each word is held for 4 edges and `pc` steps 0,1,2.
  - `done` rises at edge 12.
  - Chained to `simple_cpu`, registers end at reg0=4, reg1=7, reg3=2.
- HALT at mem[0], pulse `start`: `busy` never rises, `done`=1 next edge, `instruction` stays 0.
- No HALT anywhere with HOLD_CYCLES=1: `pc` runs 0..31 and HALTED is entered after 32 edges with `pc`=31. `pc` never wraps to 0.
- `load_en` to mem[1] during RUN: write ignored, original mem[1] is presented. `start` pulses during RUN have no effect.
- `rst` asserted at edge 6 of a run: next edge gives IDLE, `instruction`=0. A subsequent `start` replays the program from address 0 with unchanged contents.
